// File: rtl/bf_pkg.sv
// Shared definitions for the BF machine: command opcodes, output UART state type, line levels.
package bf_pkg;

    localparam logic [2:0] OP_INC   = 3'b000;
    localparam logic [2:0] OP_DEC   = 3'b001;
    localparam logic [2:0] OP_RIGHT = 3'b010;
    localparam logic [2:0] OP_LEFT  = 3'b011;
    localparam logic [2:0] OP_LOOP  = 3'b100;
    localparam logic [2:0] OP_END   = 3'b101;
    localparam logic [2:0] OP_DOT   = 3'b110;
    localparam logic [2:0] OP_COMMA = 3'b111;

    localparam logic UART_IDLE_LVL = 1'b1;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/bf_out_fifo.sv
// Small synchronous FIFO buffering output bytes between the controller and the UART transmitter.
module bf_out_fifo
    import bf_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DATA_W-1:0]           din,
    output logic [DATA_W-1:0]           dout,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/bf_output_uart.sv
// BF output stage: buffers '.' bytes and sends them as UART frames (8N1, or 8E1 when BF_OUT_PARITY_EN is defined).
module bf_output_uart
    import bf_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115_200,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ld_out,
    input  logic [DATA_W-1:0] dout,
    output logic              out_full,
    output logic              tx,
    output logic              tx_busy,
    output logic              overflow
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned BW  = $clog2(DIV + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    tx_state_t              state;
    logic [BW-1:0]          baud_cnt;
    logic [2:0]             bit_idx;
    logic [DATA_W-1:0]      shreg;
    logic [DATA_W-1:0]      fifo_q;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   has_data;
    logic                   baud_last;
    logic                   pop;

    bf_out_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (ld_out),
        .pop    (pop),
        .din    (dout),
        .dout   (fifo_q),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign has_data  = (fifo_count != '0);
    assign baud_last = (baud_cnt == BAUD_LAST);
    // Frames chain from STOP straight into START, so a pop is taken there as well as from IDLE.
    assign pop = has_data && ((state == TX_IDLE) || (state == TX_STOP && baud_last));

    assign out_full = fifo_full;
    assign tx_busy  = (state != TX_IDLE) || !fifo_empty;

    // tx is registered from the current state, so the line trails the state register by one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= UART_IDLE_LVL;
            overflow <= 1'b0;
        end else begin
            if (ld_out && fifo_full) overflow <= 1'b1;

            baud_cnt <= (state == TX_IDLE || baud_last) ? '0 : baud_cnt + 1'b1;

            case (state)
                TX_IDLE: begin
                    tx <= UART_IDLE_LVL;
                    if (pop) begin
                        state <= TX_START;
                        shreg <= fifo_q;
                    end
                end
                TX_START: begin
                    tx <= 1'b0;
                    if (baud_last) begin
                        state   <= TX_DATA;
                        bit_idx <= '0;
                    end
                end
                TX_DATA: begin
                    tx <= shreg[bit_idx];
                    if (baud_last) begin
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef BF_OUT_PARITY_EN
                            state <= TX_PARITY;
`else
                            state <= TX_STOP;
`endif
                        end
                    end
                end
                TX_PARITY: begin
                    tx <= even_parity(shreg);
                    if (baud_last) state <= TX_STOP;
                end
                TX_STOP: begin
                    tx <= UART_IDLE_LVL;
                    if (baud_last) begin
                        if (pop) begin
                            state <= TX_START;
                            shreg <= fifo_q;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule
